serial_mmio: RTL and testbench

- Memory-mapped serial port controller that sits downstream of the single-cycle processor's load/store path.
- Bridges the processor's `serial_*` pins to the external byte-stream device.
- Buffers received bytes in an RX FIFO and transmitted bytes in a TX FIFO.
- Exposes data, status and control registers. Loads are answered combinationally within the processor's single cycle; all state updates happen on the clock edge.

---
 rtl/serial_mmio_pkg.sv | 36 +++
 rtl/serial_mmio_sync_fifo.sv | 69 ++++++
 rtl/serial_mmio.sv | 129 ++++++++++++
 tb/tb_serial_mmio.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mmio_pkg.sv
// Shared register offsets, STATUS layout and reset values for the serial MMIO port.
package serial_mmio_pkg;

    // Offsets are word indices taken from mem_addr[3:2].
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;

    localparam int ST_RX_NONEMPTY  = 0;
    localparam int ST_TX_NOTFULL   = 1;
    localparam int ST_TX_DROP      = 2;
    localparam int ST_RX_COUNT_LSB = 8;
    localparam int ST_TX_COUNT_LSB = 16;

    localparam int CTRL_RX_EN = 0;
    localparam int CTRL_TX_EN = 1;
    localparam logic [1:0] CTRL_RESET = 2'b11;

    function automatic logic [31:0] status_word(
        input logic       rx_nonempty,
        input logic       tx_notfull,
        input logic       tx_drop,
        input logic [2:0] rx_count,
        input logic [2:0] tx_count
    );
        logic [31:0] w;
        w = '0;
        w[ST_RX_NONEMPTY] = rx_nonempty;
        w[ST_TX_NOTFULL]  = tx_notfull;
        w[ST_TX_DROP]     = tx_drop;
        w[ST_RX_COUNT_LSB +: 3] = rx_count;
        w[ST_TX_COUNT_LSB +: 3] = tx_count;
        return w;
    endfunction

endpackage

// File: rtl/serial_mmio_sync_fifo.sv
// Small synchronous FIFO with a combinational head; push is ignored when full, pop when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/serial_mmio.sv
// Memory-mapped serial port: DATA/STATUS/CTRL window bridging processor loads/stores to a byte-stream device.
module serial_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
    parameter int          RX_DEPTH  = 4,
    parameter int          TX_DEPTH  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic        mem_hit,
    output logic [31:0] mem_rdata,
    input  logic [7:0]  serial_in,
    input  logic        serial_valid_in,
    input  logic        serial_ready_in,
    output logic        serial_rden_out,
    output logic [7:0]  serial_out,
    output logic        serial_wren_out
);
    import serial_mmio_pkg::*;

    localparam int RCW = $clog2(RX_DEPTH) + 1;
    localparam int TCW = $clog2(TX_DEPTH) + 1;

    logic [1:0]     reg_sel;
    logic           data_rd, data_wr, status_wr, ctrl_wr;
    logic           rx_push, rx_pop, tx_push, tx_pop, tx_drop_evt;
    logic [7:0]     rx_head, tx_head;
    logic [RCW-1:0] rx_count;
    logic [TCW-1:0] tx_count;
    logic           rx_full, rx_empty, tx_full, tx_empty;

    logic [1:0]     ctrl_q, ctrl_d;
    logic           tx_drop_q, tx_drop_d;
    logic           wren_q, wren_d;
    logic [7:0]     sout_q, sout_d;
    logic           unused_bits;

    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8]};

    assign mem_hit   = (mem_addr[31:4] == BASE_ADDR[31:4]);
    assign reg_sel   = mem_addr[3:2];
    assign data_rd   = mem_hit && mem_re && (reg_sel == OFF_DATA);
    assign data_wr   = mem_hit && mem_we && (reg_sel == OFF_DATA);
    assign status_wr = mem_hit && mem_we && (reg_sel == OFF_STATUS);
    assign ctrl_wr   = mem_hit && mem_we && (reg_sel == OFF_CTRL);

    // Fetch gate uses the pre-edge count, so a same-edge pop never makes room for a push.
    assign rx_push     = !reset && ctrl_q[CTRL_RX_EN] && serial_valid_in && !rx_full;
    assign rx_pop      = data_rd && !rx_empty;
    assign tx_push     = data_wr && !tx_full;
    assign tx_drop_evt = data_wr && tx_full;
    assign tx_pop      = ctrl_q[CTRL_TX_EN] && !tx_empty && serial_ready_in;

    assign serial_rden_out = rx_push;
    assign serial_wren_out = wren_q;
    assign serial_out      = sout_q;

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (serial_in),
        .dout  (rx_head),
        .count (rx_count),
        .full  (rx_full),
        .empty (rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock (clock),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (mem_wdata[7:0]),
        .dout  (tx_head),
        .count (tx_count),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_comb begin
        mem_rdata = '0;
        if (mem_hit && mem_re) begin
            case (reg_sel)
                OFF_DATA:   mem_rdata = rx_empty ? 32'd0 : {24'd0, rx_head};
                OFF_STATUS: mem_rdata = status_word(!rx_empty, !tx_full, tx_drop_q,
                                                    3'(rx_count), 3'(tx_count));
                OFF_CTRL:   mem_rdata = {30'd0, ctrl_q};
                default:    mem_rdata = '0;
            endcase
        end
    end

    // A new drop outranks a same-cycle clear so the loss is never hidden.
    always_comb begin
        ctrl_d    = ctrl_q;
        tx_drop_d = tx_drop_q;
        wren_d    = tx_pop;
        sout_d    = tx_pop ? tx_head : sout_q;
        if (ctrl_wr) begin
            ctrl_d = mem_wdata[1:0];
        end
        if (status_wr && mem_wdata[ST_TX_DROP]) begin
            tx_drop_d = 1'b0;
        end
        if (tx_drop_evt) begin
            tx_drop_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q    <= CTRL_RESET;
            tx_drop_q <= 1'b0;
            wren_q    <= 1'b0;
            sout_q    <= 8'h00;
        end else begin
            ctrl_q    <= ctrl_d;
            tx_drop_q <= tx_drop_d;
            wren_q    <= wren_d;
            sout_q    <= sout_d;
        end
    end

endmodule

// File: tb/tb_serial_mmio.sv
// Bench for serial_mmio: directed scenarios plus random traffic against a queue-based reference model.
module tb_serial_mmio;
    localparam logic [31:0] BASE = 32'hFFFF0000;
    localparam int RXD = 4;
    localparam int TXD = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re, mem_hit;
    logic [7:0]  serial_in, serial_out;
    logic        serial_valid_in, serial_ready_in, serial_rden_out, serial_wren_out;

    always #5 clock = ~clock;

    serial_mmio #(.BASE_ADDR(BASE), .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clock           (clock),
        .reset           (reset),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .mem_re          (mem_re),
        .mem_hit         (mem_hit),
        .mem_rdata       (mem_rdata),
        .serial_in       (serial_in),
        .serial_valid_in (serial_valid_in),
        .serial_ready_in (serial_ready_in),
        .serial_rden_out (serial_rden_out),
        .serial_out      (serial_out),
        .serial_wren_out (serial_wren_out)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model state
    byte unsigned rxq[$], txq[$], devq[$], sent[$];
    bit           m_drop, m_rx_en, m_tx_en, m_wren;
    byte unsigned m_sout;
    bit           dev_on;
    int           rden_pulses;
    logic [31:0]  last_rdata;
    logic         last_wren;
    logic [7:0]   last_sout;

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_drop  = 1'b0;
        m_rx_en = 1'b1;
        m_tx_en = 1'b1;
        m_wren  = 1'b0;
        m_sout  = 8'h00;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (addr[31:4] != BASE[31:4]) return 32'd0;
        case (addr[3:2])
            2'd0: return (rxq.size() > 0) ? 32'(rxq[0]) : 32'd0;
            2'd1: return 32'(rxq.size() != 0)
                       | (32'(txq.size() < TXD) << 1)
                       | (32'(m_drop) << 2)
                       | (32'(rxq.size()) << 8)
                       | (32'(txq.size()) << 16);
            2'd2: return {30'd0, m_tx_en, m_rx_en};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input bit push_rx, input bit hit);
        bit tx_full_pre;
        logic [1:0] sel;
        sel = mem_addr[3:2];
        if (reset) begin
            model_reset();
            return;
        end
        tx_full_pre = (txq.size() >= TXD);
        if (m_tx_en && txq.size() > 0 && serial_ready_in) begin
            m_sout = txq.pop_front();
            m_wren = 1'b1;
        end else begin
            m_wren = 1'b0;
        end
        if (hit && mem_re && sel == 2'd0 && rxq.size() > 0) void'(rxq.pop_front());
        if (push_rx) begin
            rxq.push_back(serial_in);
            void'(devq.pop_front());
        end
        if (hit && mem_we) begin
            case (sel)
                2'd0: if (tx_full_pre) m_drop = 1'b1; else txq.push_back(mem_wdata[7:0]);
                2'd1: if (mem_wdata[2]) m_drop = 1'b0;
                2'd2: {m_tx_en, m_rx_en} = mem_wdata[1:0];
                default: ;
            endcase
        end
    endtask

    task automatic drive_dev();
        serial_valid_in = dev_on && (devq.size() > 0);
        serial_in       = serial_valid_in ? devq[0] : 8'($urandom);
    endtask

    task automatic tick();
        logic exp_rden, hit;
        logic [31:0] exp_rd;
        @(negedge clock);
        hit      = (mem_addr[31:4] == BASE[31:4]);
        exp_rden = !reset && m_rx_en && serial_valid_in && (rxq.size() < RXD);
        exp_rd   = mem_re ? model_read(mem_addr) : 32'd0;
        chk("hit",   32'(mem_hit),         32'(hit));
        chk("rdata", mem_rdata,            exp_rd);
        chk("rden",  32'(serial_rden_out), 32'(exp_rden));
        chk("wren",  32'(serial_wren_out), 32'(m_wren));
        chk("sout",  32'(serial_out),      32'(m_sout));
        last_rdata = mem_rdata;
        last_wren  = serial_wren_out;
        last_sout  = serial_out;
        if (serial_wren_out) sent.push_back(serial_out);
        if (serial_rden_out) rden_pulses++;
        model_edge(exp_rden, hit);
        @(posedge clock);
        #1;
        mem_we = 1'b0;
        mem_re = 1'b0;
        drive_dev();
    endtask

    task automatic op(input bit we, input bit re, input logic [1:0] sel, input logic [31:0] wd);
        mem_addr  = BASE | {28'd0, sel, 2'b00};
        mem_we    = we;
        mem_re    = re;
        mem_wdata = wd;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        mem_addr = BASE; mem_wdata = '0; mem_we = 1'b0; mem_re = 1'b0;
        serial_ready_in = 1'b0; dev_on = 1'b0; rden_pulses = 0;
        drive_dev();
        repeat (2) @(posedge clock);
        #1;
        model_reset();
        reset = 1'b0;

        // 1: reset state
        op(0, 1, 2'd1, 0);
        chk("t1_status", last_rdata, 32'h2);
        op(0, 1, 2'd2, 0);
        chk("t1_ctrl", last_rdata, 32'h3);

        // 2: RX fill to full, then drain with loads
        for (int i = 0; i < 5; i++) devq.push_back(8'(8'h11 + i));
        dev_on = 1'b1;
        drive_dev();
        rden_pulses = 0;
        repeat (7) tick();
        chk("t2_pulses", rden_pulses, 4);
        op(0, 1, 2'd1, 0);
        chk("t2_rxcount", (last_rdata >> 8) & 32'h7, 4);
        for (int i = 0; i < 4; i++) begin
            op(0, 1, 2'd0, 0);
            chk("t2_load", last_rdata, 32'h11 + i);
        end
        chk("t2_resume", rden_pulses, 5);
        op(0, 1, 2'd0, 0);
        chk("t2_tail", last_rdata, 32'h15);

        // 3: empty load, then push and pop on one edge
        op(0, 1, 2'd0, 0);
        chk("t3_empty", last_rdata, 32'h0);
        op(0, 1, 2'd1, 0);
        chk("t3_cnt0", (last_rdata >> 8) & 32'h7, 0);
        devq = '{8'h21, 8'h22, 8'h23};
        drive_dev();
        repeat (4) tick();
        devq.push_back(8'h24);
        drive_dev();
        op(0, 1, 2'd0, 0);
        chk("t3_head", last_rdata, 32'h21);
        dev_on = 1'b0;
        drive_dev();
        op(0, 1, 2'd1, 0);
        chk("t3_cnt3", (last_rdata >> 8) & 32'h7, 3);
        op(0, 1, 2'd0, 0);
        chk("t3_next", last_rdata, 32'h22);
        repeat (3) op(0, 1, 2'd0, 0);

        // 4: TX overflow, sticky drop, clear, ordered drain
        serial_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) op(1, 0, 2'd0, 32'hA0 + i);
        op(0, 1, 2'd1, 0);
        chk("t4_txcount", (last_rdata >> 16) & 32'h7, 4);
        chk("t4_drop", (last_rdata >> 2) & 32'h1, 1);
        chk("t4_notfull", (last_rdata >> 1) & 32'h1, 0);
        op(1, 0, 2'd1, 32'h4);
        op(0, 1, 2'd1, 0);
        chk("t4_clr", (last_rdata >> 2) & 32'h1, 0);
        sent.delete();
        serial_ready_in = 1'b1;
        repeat (6) tick();
        chk("t4_nsent", sent.size(), 4);
        for (int i = 0; i < 4 && i < sent.size(); i++) chk("t4_byte", sent[i], 32'hA0 + i);

        // 5: store-to-wren latency
        op(1, 0, 2'd0, 32'h5A);
        tick();
        chk("t5_e1_wren", 32'(last_wren), 0);
        tick();
        chk("t5_e2_wren", 32'(last_wren), 1);
        chk("t5_e2_out", 32'(last_sout), 32'h5A);

        // 6: reset mid-traffic
        devq = '{8'h31, 8'h32, 8'h33};
        dev_on = 1'b1;
        drive_dev();
        repeat (5) tick();
        dev_on = 1'b0;
        drive_dev();
        op(1, 0, 2'd2, 32'h2);
        serial_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) op(1, 0, 2'd0, 32'hB0 + i);
        serial_ready_in = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        op(0, 1, 2'd1, 0);
        chk("t6_status", last_rdata, 32'h2);
        chk("t6_wren", 32'(last_wren), 0);
        op(0, 1, 2'd2, 0);
        chk("t6_ctrl", last_rdata, 32'h3);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [1:0] sel;
            if (devq.size() < 3) devq.push_back(8'($urandom));
            dev_on          = ($urandom_range(0, 3) != 0);
            serial_ready_in = 1'($urandom_range(0, 1));
            sel             = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) mem_addr = $urandom;
            else mem_addr = BASE | {28'd0, sel, 2'($urandom_range(0, 3))};
            mem_we    = ($urandom_range(0, 2) == 0);
            mem_re    = 1'($urandom_range(0, 1));
            mem_wdata = $urandom;
            if (sel == 2'd2 && $urandom_range(0, 3) != 0) mem_wdata[1:0] = 2'b11;
            reset     = ($urandom_range(0, 99) == 0);
            drive_dev();
            tick();
        end
        reset = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
